// File: rtl/pio_input_conditioner.sv
// PIO input front end: two-flop synchroniser, per-bit debounce filter, edge
// capture with level interrupt, and an Avalon-style register slave.
module pio_input_conditioner #(
  parameter int unsigned pBITS     = 32,
  parameter int unsigned pDEB_BITS = 16
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [3:0]       iADDRESS,
  input  logic             iWRITE,
  input  logic             iREAD,
  input  logic [31:0]      iWRITE_DATA,
  output logic [31:0]      oREAD_DATA,
  input  logic [pBITS-1:0] iPIN,
  output logic [pBITS-1:0] oPIO,
  output logic             oIRQ
);

  localparam logic [pDEB_BITS-1:0] PCNT_ONE = 1;

  logic [pBITS-1:0]     sync1_q, sync2_q;
  logic [pBITS-1:0]     pio_q, pio_d;
  logic [1:0]           cnt_q [pBITS];
  logic [1:0]           cnt_d [pBITS];
  logic [pBITS-1:0]     deben_q, deben_d;
  logic [pBITS-1:0]     risemsk_q, risemsk_d;
  logic [pBITS-1:0]     fallmsk_q, fallmsk_d;
  logic [pBITS-1:0]     edge_q, edge_d;
  logic [pDEB_BITS-1:0] period_q, period_d;
  logic [pDEB_BITS-1:0] pcnt_q, pcnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 irq_q, irq_d;

  logic                 wr_deben, wr_rise, wr_fall, wr_edge, wr_period;
  logic                 tick;
  logic [pBITS-1:0]     rise, fall, w1c;

  always_comb begin
    wr_deben  = iWRITE && (iADDRESS == 4'd1);
    wr_rise   = iWRITE && (iADDRESS == 4'd2);
    wr_fall   = iWRITE && (iADDRESS == 4'd3);
    wr_edge   = iWRITE && (iADDRESS == 4'd4);
    wr_period = iWRITE && (iADDRESS == 4'd5);
  end

  // A PERIOD write restarts the prescaler and suppresses that cycle's tick.
  always_comb begin
    tick     = (pcnt_q == period_q) && !wr_period;
    pcnt_d   = (wr_period || tick) ? '0 : pcnt_q + PCNT_ONE;
    period_d = wr_period ? iWRITE_DATA[pDEB_BITS-1:0] : period_q;
  end

  always_comb begin
    deben_d   = wr_deben ? iWRITE_DATA[pBITS-1:0] : deben_q;
    risemsk_d = wr_rise  ? iWRITE_DATA[pBITS-1:0] : risemsk_q;
    fallmsk_d = wr_fall  ? iWRITE_DATA[pBITS-1:0] : fallmsk_q;
  end

  always_comb begin
    pio_d = pio_q;
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < pBITS; i++) begin
      if (!deben_q[i]) begin
        pio_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else if (tick) begin
        if (sync2_q[i] == pio_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] != 2'd2) begin
          cnt_d[i] = cnt_q[i] + 2'd1;
        end else begin
          pio_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Newly detected edges override a simultaneous write-one-to-clear.
  always_comb begin
    rise   = pio_d & ~pio_q;
    fall   = ~pio_d & pio_q;
    w1c    = wr_edge ? iWRITE_DATA[pBITS-1:0] : '0;
    edge_d = (edge_q & ~w1c) | (rise & risemsk_q) | (fall & fallmsk_q);
    irq_d  = |edge_d;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (iREAD) begin
      rdata_d = '0;
      case (iADDRESS)
        4'd0:    rdata_d[pBITS-1:0]     = pio_q;
        4'd1:    rdata_d[pBITS-1:0]     = deben_q;
        4'd2:    rdata_d[pBITS-1:0]     = risemsk_q;
        4'd3:    rdata_d[pBITS-1:0]     = fallmsk_q;
        4'd4:    rdata_d[pBITS-1:0]     = edge_q;
        4'd5:    rdata_d[pDEB_BITS-1:0] = period_q;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pio_q     <= '0;
      cnt_q     <= '{default: '0};
      deben_q   <= '0;
      risemsk_q <= '0;
      fallmsk_q <= '0;
      edge_q    <= '0;
      period_q  <= '0;
      pcnt_q    <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      sync1_q   <= iPIN;
      sync2_q   <= sync1_q;
      pio_q     <= pio_d;
      cnt_q     <= cnt_d;
      deben_q   <= deben_d;
      risemsk_q <= risemsk_d;
      fallmsk_q <= fallmsk_d;
      edge_q    <= edge_d;
      period_q  <= period_d;
      pcnt_q    <= pcnt_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign oPIO       = pio_q;
  assign oREAD_DATA = rdata_q;
  assign oIRQ       = irq_q;

endmodule
